// File: rtl/tmod_pkg.sv
// tmod_pkg: shared opcode/status/state types and helpers for the tmod bus master.
package tmod_pkg;

  // tmod bus opcodes; 8..15 are all NOOP, OP_NOOP is the canonical idle value
  typedef enum logic [3:0] {
    OP_RESET    = 4'h0,
    OP_SET_FRQ  = 4'h1,
    OP_SET_HIGH = 4'h2,
    OP_SET_LOW  = 4'h3,
    OP_OUT_MAX  = 4'h4,
    OP_OUT_MIN  = 4'h5,
    OP_OUT_ADDR = 4'h6,
    OP_OUT_AVG  = 4'h7,
    OP_NOOP     = 4'h8
  } opcode_t;

  // Slave status encoding; 2'b11 is not listed and behaves like OK
  typedef enum logic [1:0] {
    STAT_OK   = 2'b00,
    STAT_LOW  = 2'b01,
    STAT_HIGH = 2'b10
  } status_t;

  // Master sequencer states
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_GAP       = 2'd2,
    S_WAIT_DATA = 2'd3
  } state_t;

  // Read-type opcodes return data from the slave
  function automatic logic is_read(input logic [3:0] op);
    return (op >= 4'h4) && (op <= 4'h7);
  endfunction

endpackage

// File: rtl/tmod_cmd_fifo.sv
// tmod_cmd_fifo: small synchronous command queue with registered full/empty flags.
// Head data is a direct read of the entry at the read pointer.
module tmod_cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             not_full,
  output logic             empty
);

  localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow even if the caller misbehaves
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and flags; flags are registered from next occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      not_full <= 1'b1;
      empty    <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      count    <= count_next;
      full     <= (count_next == DEPTH_C);
      not_full <= (count_next != DEPTH_C);
      empty    <= (count_next == '0);
    end
  end

endmodule

// File: rtl/tmod_master.sv
// tmod_master: host-side command sequencer for the tmod temperature-monitor slave.
// Queues commands, issues them one per ISSUE cycle, collects read data or times
// out, and debounces the slave status into high/low alarms.
// Optional statistics counters are built when TMOD_MASTER_STATS_EN is defined.
module tmod_master #(
  parameter int DATA_W        = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int TIMEOUT_CYC   = 255,
  parameter int ALARM_PERSIST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_opnd,
  output logic              rsp_valid,
  output logic [3:0]        rsp_op,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [3:0]        bus_op,
  output logic [DATA_W-1:0] bus_opnd,
  input  logic              bus_ready,
  input  logic              bus_valid,
  input  logic [DATA_W-1:0] bus_data,
  input  logic [1:0]        bus_status,
  output logic              alarm_high,
  output logic              alarm_low,
  output logic [15:0]       stat_cmds,
  output logic [7:0]        stat_timeouts
);

  import tmod_pkg::*;

  localparam int EW = 4 + DATA_W;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int AW = $clog2(ALARM_PERSIST + 1);

  // The timer is cleared when the head is popped and runs through ISSUE and
  // WAIT_DATA, so it equals the number of cycles since ISSUE began. The timeout
  // response is registered on the edge where it would reach TIMEOUT_CYC, which
  // puts rsp_valid exactly TIMEOUT_CYC cycles after the ISSUE cycle.
  // TIMEOUT_CYC is expected to be at least 2.
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [AW-1:0] PERS_LAST = AW'(ALARM_PERSIST - 1);
  localparam logic [AW-1:0] PERS_MAX  = AW'(ALARM_PERSIST);

  state_t            state;
  logic [3:0]        cur_op;
  logic [TW-1:0]     timer;
  logic [GW-1:0]     gap_cnt;

  logic              fifo_push;
  logic              fifo_pop;
  logic [EW-1:0]     fifo_head;
  logic              fifo_full;
  logic              fifo_not_full;
  logic              fifo_empty;
  logic [3:0]        head_op;
  logic [DATA_W-1:0] head_opnd;
  logic              timeout_hit;
  logic              op_reset_issue;

  logic [AW-1:0]     hi_cnt;
  logic [AW-1:0]     hi_clr_cnt;
  logic [AW-1:0]     lo_cnt;
  logic [AW-1:0]     lo_clr_cnt;
  logic              is_high;
  logic              is_low;
  logic              set_high;
  logic              clr_high;
  logic              set_low;
  logic              clr_low;

  assign cmd_ready = fifo_not_full;
  assign fifo_push = cmd_valid & ~fifo_full;
  assign fifo_pop  = (state == S_IDLE) & ~fifo_empty & bus_ready;
  assign head_op   = fifo_head[EW-1 -: 4];
  assign head_opnd = fifo_head[DATA_W-1:0];

  assign timeout_hit    = (state == S_WAIT_DATA) & ~bus_valid & (timer == TO_LAST);
  assign op_reset_issue = (state == S_ISSUE) & (cur_op == OP_RESET);

  tmod_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .din      ({cmd_op, cmd_opnd}),
    .head     (fifo_head),
    .full     (fifo_full),
    .not_full (fifo_not_full),
    .empty    (fifo_empty)
  );

  // Sequencer: pop, drive one ISSUE cycle, then gap (writes) or wait for data (reads)
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_op    <= 4'h0;
      timer     <= '0;
      gap_cnt   <= '0;
      bus_op    <= OP_NOOP;
      bus_opnd  <= '0;
      rsp_valid <= 1'b0;
      rsp_op    <= 4'h0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            bus_op   <= head_op;
            bus_opnd <= head_opnd;
            cur_op   <= head_op;
            timer    <= '0;
            state    <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          bus_op   <= OP_NOOP;
          bus_opnd <= '0;
          timer    <= timer + 1'b1;
          gap_cnt  <= '0;
          if (is_read(cur_op)) begin
            state <= S_WAIT_DATA;
          end else if (GAP_CYCLES == 0) begin
            state <= S_IDLE;
          end else begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_WAIT_DATA: begin
          // Data arriving on the timeout cycle takes priority
          if (bus_valid) begin
            rsp_valid <= 1'b1;
            rsp_op    <= cur_op;
            rsp_data  <= bus_data;
            rsp_err   <= 1'b0;
            state     <= S_IDLE;
          end else if (timeout_hit) begin
            rsp_valid <= 1'b1;
            rsp_op    <= cur_op;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            state     <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          bus_op   <= OP_NOOP;
          bus_opnd <= '0;
        end
      endcase
    end
  end

  assign is_high  = (bus_status == STAT_HIGH);
  assign is_low   = (bus_status == STAT_LOW);
  assign set_high = is_high & (hi_cnt >= PERS_LAST);
  assign clr_high = ~is_high & (hi_clr_cnt >= PERS_LAST);
  assign set_low  = is_low & (lo_cnt >= PERS_LAST);
  assign clr_low  = ~is_low & (lo_clr_cnt >= PERS_LAST);

  // Status debounce: saturating persistence counters drive mutually exclusive alarms
  always_ff @(posedge clk) begin
    if (reset || op_reset_issue) begin
      hi_cnt     <= '0;
      hi_clr_cnt <= '0;
      lo_cnt     <= '0;
      lo_clr_cnt <= '0;
      alarm_high <= 1'b0;
      alarm_low  <= 1'b0;
    end else begin
      if (is_high) begin
        hi_cnt     <= (hi_cnt == PERS_MAX) ? hi_cnt : hi_cnt + 1'b1;
        hi_clr_cnt <= '0;
      end else begin
        hi_cnt     <= '0;
        hi_clr_cnt <= (hi_clr_cnt == PERS_MAX) ? hi_clr_cnt : hi_clr_cnt + 1'b1;
      end
      if (is_low) begin
        lo_cnt     <= (lo_cnt == PERS_MAX) ? lo_cnt : lo_cnt + 1'b1;
        lo_clr_cnt <= '0;
      end else begin
        lo_cnt     <= '0;
        lo_clr_cnt <= (lo_clr_cnt == PERS_MAX) ? lo_clr_cnt : lo_clr_cnt + 1'b1;
      end
      if (set_high) begin
        alarm_high <= 1'b1;
        alarm_low  <= 1'b0;
      end else if (set_low) begin
        alarm_low  <= 1'b1;
        alarm_high <= 1'b0;
      end else begin
        if (clr_high) begin
          alarm_high <= 1'b0;
        end
        if (clr_low) begin
          alarm_low <= 1'b0;
        end
      end
    end
  end

`ifdef TMOD_MASTER_STATS_EN
  // Saturating counts of issued commands and read timeouts
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cmds     <= 16'h0000;
      stat_timeouts <= 8'h00;
    end else begin
      if ((state == S_ISSUE) && (stat_cmds != 16'hFFFF)) begin
        stat_cmds <= stat_cmds + 16'h0001;
      end
      if (timeout_hit && (stat_timeouts != 8'hFF)) begin
        stat_timeouts <= stat_timeouts + 8'h01;
      end
    end
  end
`else
  assign stat_cmds     = 16'h0000;
  assign stat_timeouts = 8'h00;
`endif

endmodule

// File: tb/tb_tmod_master.sv
// tb_tmod_master: directed bench for tmod_master with issue/response scoreboards.
module tb_tmod_master;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_opnd;
  logic       rsp_valid;
  logic [3:0] rsp_op;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [3:0] bus_op;
  logic [7:0] bus_opnd;
  logic       bus_ready;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic [1:0] bus_status;
  logic       alarm_high;
  logic       alarm_low;
  logic [15:0] stat_cmds;
  logic [7:0]  stat_timeouts;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_issue [$];
  logic [12:0] exp_rsp   [$];
  logic [11:0] mon_issue;
  logic [12:0] mon_rsp;

  logic [3:0] t4_op   [5] = '{4'h1, 4'h2, 4'h3, 4'h1, 4'h3};
  logic [7:0] t4_opnd [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [15:0] exp_cmds;
  logic [7:0]  exp_tos;

  tmod_master dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_opnd      (cmd_opnd),
    .rsp_valid     (rsp_valid),
    .rsp_op        (rsp_op),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .bus_op        (bus_op),
    .bus_opnd      (bus_opnd),
    .bus_ready     (bus_ready),
    .bus_valid     (bus_valid),
    .bus_data      (bus_data),
    .bus_status    (bus_status),
    .alarm_high    (alarm_high),
    .alarm_low     (alarm_low),
    .stat_cmds     (stat_cmds),
    .stat_timeouts (stat_timeouts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command for one cycle and record the issue it must produce
  task automatic push_cmd(input logic [3:0] op, input logic [7:0] opnd);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_opnd  = opnd;
    exp_issue.push_back({op, opnd});
    tick();
    cmd_valid = 1'b0;
  endtask

  // Scoreboard monitor: every non-NOOP bus cycle and every response is popped and compared
  always @(posedge clk) begin
    #2;
    if (bus_op !== 4'h8) begin
      n_checks++;
      assert (exp_issue.size() != 0) else begin
        n_fail++;
        $error("FAIL issue_unexpected observed=%0h expected=none", {bus_op, bus_opnd});
      end
      if (exp_issue.size() != 0) begin
        mon_issue = exp_issue.pop_front();
        n_checks++;
        assert ({bus_op, bus_opnd} === mon_issue) else begin
          n_fail++;
          $error("FAIL issue_order observed=%0h expected=%0h", {bus_op, bus_opnd}, mon_issue);
        end
      end
    end
    if (rsp_valid !== 1'b0) begin
      n_checks++;
      assert (exp_rsp.size() != 0) else begin
        n_fail++;
        $error("FAIL rsp_unexpected observed=%0h expected=none", {rsp_op, rsp_data, rsp_err});
      end
      if (exp_rsp.size() != 0) begin
        mon_rsp = exp_rsp.pop_front();
        n_checks++;
        assert ({rsp_op, rsp_data, rsp_err} === mon_rsp) else begin
          n_fail++;
          $error("FAIL rsp_payload observed=%0h expected=%0h", {rsp_op, rsp_data, rsp_err}, mon_rsp);
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 4'h0;
    cmd_opnd   = 8'h00;
    bus_ready  = 1'b0;
    bus_valid  = 1'b0;
    bus_data   = 8'h00;
    bus_status = 2'b00;
    repeat (3) tick();

    // Reset values
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_op, rsp_data, rsp_err}, 0);
    chk("rst_bus_op", bus_op, 4'h8);
    chk("rst_bus_opnd", bus_opnd, 0);
    chk("rst_alarms", {alarm_high, alarm_low}, 0);
    chk("rst_stats", {stat_cmds, stat_timeouts}, 0);
    reset = 1'b0;
    tick();

    // Write command: one ISSUE cycle then NOOP gap, no response
    bus_ready = 1'b1;
    push_cmd(4'h2, 8'h50);
    chk("wr_latency_noop", bus_op, 4'h8);
    tick();
    chk("wr_issue_op", bus_op, 4'h2);
    chk("wr_issue_opnd", bus_opnd, 8'h50);
    tick();
    chk("wr_gap1_op", bus_op, 4'h8);
    chk("wr_gap1_opnd", bus_opnd, 0);
    tick();
    chk("wr_gap2_op", bus_op, 4'h8);
    chk("wr_no_rsp", rsp_valid, 0);
    tick();

    // Read with data three cycles after ISSUE
    push_cmd(4'h4, 8'h00);
    tick();
    chk("rd_issue_op", bus_op, 4'h4);
    repeat (3) tick();
    bus_valid = 1'b1;
    bus_data  = 8'h3C;
    exp_rsp.push_back({4'h4, 8'h3C, 1'b0});
    chk("rd_rsp_not_yet", rsp_valid, 0);
    tick();
    bus_valid = 1'b0;
    bus_data  = 8'h00;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_data, 8'h3C);
    chk("rd_rsp_op", rsp_op, 4'h4);
    chk("rd_rsp_err", rsp_err, 0);
    tick();
    chk("rd_rsp_one_cycle", rsp_valid, 0);

    // Read that times out exactly 255 cycles after ISSUE
    push_cmd(4'h7, 8'h00);
    tick();
    chk("to_issue_op", bus_op, 4'h7);
    exp_rsp.push_back({4'h7, 8'h00, 1'b1});
    for (int i = 1; i < 255; i++) tick();
    chk("to_not_early", rsp_valid, 0);
    tick();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
`ifdef TMOD_MASTER_STATS_EN
    exp_cmds = 16'd3;
    exp_tos  = 8'd1;
`else
    exp_cmds = 16'd0;
    exp_tos  = 8'd0;
`endif
    chk("stat_cmds", stat_cmds, exp_cmds);
    chk("stat_timeouts", stat_timeouts, exp_tos);
    tick();

    // Fill the queue with the slave not ready; fifth push must be refused
    bus_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = t4_op[i];
      cmd_opnd  = t4_opnd[i];
      if (i < 4) begin
        chk("fill_cmd_ready", cmd_ready, 1);
        exp_issue.push_back({t4_op[i], t4_opnd[i]});
      end else begin
        chk("full_cmd_ready", cmd_ready, 0);
      end
      tick();
    end
    cmd_valid = 1'b0;
    repeat (3) tick();
    chk("not_ready_hold", bus_op, 4'h8);
    bus_ready = 1'b1;
    for (int c = 0; c < 40 && exp_issue.size() != 0; c++) tick();
    chk("fifo_drained", exp_issue.size(), 0);
    chk("cmd_ready_back", cmd_ready, 1);
    repeat (5) tick();

    // Alarm debounce: 3 HIGH cycles are not enough
    bus_status = 2'b10;
    repeat (3) tick();
    bus_status = 2'b00;
    tick();
    chk("hi3_no_alarm", alarm_high, 0);
    bus_status = 2'b10;
    repeat (3) tick();
    chk("hi_before_4th", alarm_high, 0);
    tick();
    chk("hi4_alarm", alarm_high, 1);
    bus_status = 2'b00;
    repeat (3) tick();
    chk("hi_clear_hold", alarm_high, 1);
    tick();
    chk("hi_cleared", alarm_high, 0);

    // LOW alarm, then HIGH takes over with LOW dropped
    bus_status = 2'b01;
    repeat (4) tick();
    chk("lo4_alarm", {alarm_high, alarm_low}, 2'b01);
    bus_status = 2'b10;
    repeat (4) tick();
    chk("hi_over_lo", {alarm_high, alarm_low}, 2'b10);

    // RESET opcode clears an active alarm on its ISSUE cycle
    push_cmd(4'h0, 8'h00);
    tick();
    chk("rstop_issue", bus_op, 4'h0);
    chk("rstop_alarm_before", alarm_high, 1);
    bus_status = 2'b00;
    tick();
    chk("rstop_alarm_cleared", alarm_high, 0);
    repeat (4) tick();

    // Reset while waiting for read data abandons the read and flushes the queue
    push_cmd(4'h5, 8'h0A);
    push_cmd(4'h1, 8'h99);
    chk("mid_issue_op", bus_op, 4'h5);
    repeat (2) tick();
    reset = 1'b1;
    exp_issue.delete();
    tick();
    reset = 1'b0;
    chk("mid_rst_bus_op", bus_op, 4'h8);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_stats", {stat_cmds, stat_timeouts}, 0);
    bus_valid = 1'b1;
    bus_data  = 8'h77;
    tick();
    bus_valid = 1'b0;
    bus_data  = 8'h00;
    tick();
    chk("mid_rst_late_valid", rsp_valid, 0);
    repeat (8) tick();
    chk("mid_rst_flushed", bus_op, 4'h8);

    // Normal operation resumes after reset
    push_cmd(4'h6, 8'h00);
    tick();
    chk("post_issue_op", bus_op, 4'h6);
    tick();
    bus_valid = 1'b1;
    bus_data  = 8'hA5;
    exp_rsp.push_back({4'h6, 8'hA5, 1'b0});
    tick();
    bus_valid = 1'b0;
    bus_data  = 8'h00;
    chk("post_rsp_valid", rsp_valid, 1);
    chk("post_rsp_data", rsp_data, 8'hA5);
    repeat (3) tick();
    chk("end_issue_queue", exp_issue.size(), 0);
    chk("end_rsp_queue", exp_rsp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
